// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory responder.
// Holds the I/O register offsets (relative to the MMIO base), the address
// region type and the address decoder that classifies a byte address.
package cpu_mem_pkg;

    localparam logic [15:0] LED_OFS = 16'h0;
    localparam logic [15:0] SW_OFS  = 16'h2;
    localparam logic [15:0] CNT_OFS = 16'h4;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_HOLE
    } region_e;

    // RAM occupies [0, ram_bytes); I/O occupies [mmio_base, 0xFFFF]; the rest is a hole.
    function automatic region_e decode_region(input logic [15:0] addr,
                                              input logic [16:0] ram_bytes,
                                              input logic [15:0] mmio_base);
        if ({1'b0, addr} < ram_bytes) begin
            return REG_RAM;
        end else if (addr >= mmio_base) begin
            return REG_MMIO;
        end else begin
            return REG_HOLE;
        end
    endfunction

endpackage

// File: rtl/mem_dp_ram.sv
// Dual-port word RAM.
// Port A: read-only, registered read data (updates only when a_en_i is high).
// Port B: read/write, registered read data (updates only when b_re_i is high);
//         a read and write to the same word on one edge returns the old word.
// Ports:
//   clk_i                         clock
//   a_en_i, a_addr_i, a_rdata_o   port A read enable, word address, read data
//   b_re_i, b_we_i                port B read / write enables
//   b_addr_i, b_wdata_i           port B word address, write data
//   b_rdata_o                     port B read data
// Contents are not reset.
module mem_dp_ram #(
    parameter int unsigned Words    = 4096,
    parameter int unsigned Width    = 16,
    parameter int unsigned AddrW    = $clog2(Words),
    parameter string       InitFile = ""
) (
    input  logic             clk_i,
    input  logic             a_en_i,
    input  logic [AddrW-1:0] a_addr_i,
    output logic [Width-1:0] a_rdata_o,
    input  logic             b_re_i,
    input  logic             b_we_i,
    input  logic [AddrW-1:0] b_addr_i,
    input  logic [Width-1:0] b_wdata_i,
    output logic [Width-1:0] b_rdata_o
);

    logic [Width-1:0] mem_q [Words];
    logic [Width-1:0] a_rdata_q;
    logic [Width-1:0] b_rdata_q;

    always_ff @(posedge clk_i) begin
        if (a_en_i) begin
            a_rdata_q <= mem_q[a_addr_i];
        end
        if (b_we_i) begin
            mem_q[b_addr_i] <= b_wdata_i;
        end
        // Non-blocking read of the array gives read-before-write.
        if (b_re_i) begin
            b_rdata_q <= mem_q[b_addr_i];
        end
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/cpu_mem_responder.sv
// Responder for the CPU's fetch (pc) and load/store (ldst) memory ports.
// Both ports share a dual-port word RAM; ldst additionally reaches an I/O
// region with an LED register, synchronised switches and a cycle counter.
// All reads return data one cycle after the request; rddata holds otherwise.
// Ports:
//   clk, reset (async, active-low)
//   i_pc_addr, i_pc_rd, o_pc_rddata                       fetch port
//   i_ldst_addr, i_ldst_rd, i_ldst_wr, i_ldst_wrdata,
//   o_ldst_rddata                                         load/store port
//   i_switches (async), o_leds                            board I/O
//   o_err                                                 sticky protocol error
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 4096,
    parameter logic [15:0] MMIO_BASE = 16'hF000,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] i_pc_addr,
    input  logic        i_pc_rd,
    output logic [15:0] o_pc_rddata,
    input  logic [15:0] i_ldst_addr,
    input  logic        i_ldst_rd,
    input  logic        i_ldst_wr,
    input  logic [15:0] i_ldst_wrdata,
    output logic [15:0] o_ldst_rddata,
    input  logic [9:0]  i_switches,
    output logic [9:0]  o_leds,
    output logic        o_err
);

    localparam int unsigned RAM_AW    = $clog2(RAM_WORDS);
    localparam logic [16:0] RAM_BYTES = 17'(2 * RAM_WORDS);

    region_e     pc_region;
    region_e     ldst_region;
    logic [15:0] ldst_ofs;
    logic        ldst_rd_ok;
    logic        pc_ram_rd;
    logic        ldst_ram_rd;
    logic        ldst_ram_wr;
    logic [15:0] mmio_rdata;
    logic [15:0] ram_a_rdata;
    logic [15:0] ram_b_rdata;

    // Output selects: the RAM data registers cannot be reset, so the port
    // outputs are gated by resettable select flops instead.
    logic        pc_sel_ram_q, pc_sel_ram_d;
    logic        ldst_sel_ram_q, ldst_sel_ram_d;
    logic [15:0] ldst_mmio_q, ldst_mmio_d;
    logic [9:0]  leds_q, leds_d;
    logic [15:0] cnt_q, cnt_d;
    logic [9:0]  sw_meta_q, sw_meta_d;
    logic [9:0]  sw_sync_q, sw_sync_d;
    logic        err_q, err_d;

    assign pc_region   = decode_region(i_pc_addr, RAM_BYTES, MMIO_BASE);
    assign ldst_region = decode_region(i_ldst_addr, RAM_BYTES, MMIO_BASE);
    // addr[0] is ignored, so MMIO_BASE+1 aliases the LED register.
    assign ldst_ofs    = {i_ldst_addr[15:1], 1'b0} - MMIO_BASE;

    // A simultaneous rd+wr is an error: the write proceeds, the read is dropped.
    assign ldst_rd_ok  = i_ldst_rd & ~i_ldst_wr;
    assign pc_ram_rd   = i_pc_rd & (pc_region == REG_RAM);
    assign ldst_ram_rd = ldst_rd_ok & (ldst_region == REG_RAM);
    assign ldst_ram_wr = i_ldst_wr & (ldst_region == REG_RAM);

    always_comb begin
        case (ldst_ofs)
            LED_OFS: mmio_rdata = {6'b0, leds_q};
            SW_OFS:  mmio_rdata = {6'b0, sw_sync_q};
            CNT_OFS: mmio_rdata = cnt_q;
            default: mmio_rdata = 16'h0000;
        endcase
    end

    always_comb begin
        pc_sel_ram_d   = pc_sel_ram_q;
        ldst_sel_ram_d = ldst_sel_ram_q;
        ldst_mmio_d    = ldst_mmio_q;
        leds_d         = leds_q;
        cnt_d          = cnt_q + 16'd1;
        sw_meta_d      = i_switches;
        sw_sync_d      = sw_meta_q;
        err_d          = err_q
                       | (i_ldst_rd & i_ldst_wr)
                       | ((i_ldst_rd | i_ldst_wr) & i_ldst_addr[0])
                       | (i_pc_rd & i_pc_addr[0]);

        if (i_pc_rd) begin
            pc_sel_ram_d = (pc_region == REG_RAM);
        end

        if (ldst_rd_ok) begin
            ldst_sel_ram_d = (ldst_region == REG_RAM);
            ldst_mmio_d    = (ldst_region == REG_MMIO) ? mmio_rdata : 16'h0000;
        end

        // A counter load overrides this cycle's increment.
        if (i_ldst_wr && (ldst_region == REG_MMIO)) begin
            case (ldst_ofs)
                LED_OFS: leds_d = i_ldst_wrdata[9:0];
                CNT_OFS: cnt_d  = i_ldst_wrdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_sel_ram_q   <= 1'b0;
            ldst_sel_ram_q <= 1'b0;
            ldst_mmio_q    <= 16'h0000;
            leds_q         <= 10'h000;
            cnt_q          <= 16'h0000;
            sw_meta_q      <= 10'h000;
            sw_sync_q      <= 10'h000;
            err_q          <= 1'b0;
        end else begin
            pc_sel_ram_q   <= pc_sel_ram_d;
            ldst_sel_ram_q <= ldst_sel_ram_d;
            ldst_mmio_q    <= ldst_mmio_d;
            leds_q         <= leds_d;
            cnt_q          <= cnt_d;
            sw_meta_q      <= sw_meta_d;
            sw_sync_q      <= sw_sync_d;
            err_q          <= err_d;
        end
    end

    mem_dp_ram #(
        .Words    (RAM_WORDS),
        .Width    (16),
        .AddrW    (RAM_AW),
        .InitFile (INIT_FILE)
    ) u_ram (
        .clk_i     (clk),
        .a_en_i    (pc_ram_rd),
        .a_addr_i  (i_pc_addr[RAM_AW:1]),
        .a_rdata_o (ram_a_rdata),
        .b_re_i    (ldst_ram_rd),
        .b_we_i    (ldst_ram_wr),
        .b_addr_i  (i_ldst_addr[RAM_AW:1]),
        .b_wdata_i (i_ldst_wrdata),
        .b_rdata_o (ram_b_rdata)
    );

    assign o_pc_rddata   = pc_sel_ram_q ? ram_a_rdata : 16'h0000;
    assign o_ldst_rddata = ldst_sel_ram_q ? ram_b_rdata : ldst_mmio_q;
    assign o_leds        = leds_q;
    assign o_err         = err_q;

endmodule
